bcd_add_sequencer: RTL and testbench

Multi-digit BCD adder controller. Accepts two DIGITS-wide packed BCD operands over a valid/ready handshake, then drives one shared 4-bit digit adder one digit per cycle, least-significant digit first, rippling the decimal carry. It returns the packed BCD result, a carry-out and an invalid-digit flag over a second valid/ready handshake. It sits between operand producers and the digit-level conversion/adder datapath, and sequences that datapath so it does not have to be replicated per digit.

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_digit_adder.sv | 36 +++
 rtl/bcd_add_sequencer.sv | 133 +++++++++++++
 tb/tb_bcd_add_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD add sequencer and its digit adder.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;
  localparam int BCD_ADJ = 6;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nines complement of one digit.
  // Digits above 9 wrap modulo 16 so the result is still deterministic.
  function automatic bcd_digit_t nines(input bcd_digit_t d);
    return bcd_digit_t'(BCD_MAX) - d;
  endfunction

  // A digit is legal BCD only if it lies in the range 0..9.
  function automatic logic is_bad(input bcd_digit_t d);
    return d > bcd_digit_t'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit decimal adder with an optional nines-complement of b (subtract).
// Purely combinational; the sequencer time-shares a single instance.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       sub,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout,
  output logic       invalid
);

  bcd_digit_t           b_eff;
  logic [DIGIT_W:0]     s_raw;
  logic [DIGIT_W:0]     s_adj;

  // Binary add of a, (possibly complemented) b and carry, then decimal adjust.
  // The adjust is applied whatever the inputs, including illegal digits.
  always_comb begin
    b_eff   = sub ? nines(b) : b;
    s_raw   = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
    s_adj   = s_raw + (DIGIT_W+1)'(BCD_ADJ);
    if (s_raw > (DIGIT_W+1)'(BCD_MAX)) begin
      sum  = s_adj[DIGIT_W-1:0];
      cout = 1'b1;
    end else begin
      sum  = s_raw[DIGIT_W-1:0];
      cout = 1'b0;
    end
    // Flag the original operand digits, not the complemented b.
    invalid = is_bad(a) | is_bad(b);
  end

endmodule

// File: rtl/bcd_add_sequencer.sv
// Multi-digit BCD add sequencer: latches two packed BCD operands, then ripples
// through them LSD first with one shared digit adder, one digit per cycle.
// Optional feature: define BCD_SUB_EN to add the op port (1 = A - B, computed
// as A + nines(B) + 1).
module bcd_add_sequencer
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
`ifdef BCD_SUB_EN
  input  logic                    op,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                    carry_out,
  output logic                    digit_err
);

  localparam int                IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(DIGITS - 1);

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         idx;
  bcd_digit_t [DIGITS-1:0]  a_r;
  bcd_digit_t [DIGITS-1:0]  b_r;
  bcd_digit_t [DIGITS-1:0]  sum_r;
  logic                     carry;
  logic                     carry_out_r;
  logic                     err_r;
`ifdef BCD_SUB_EN
  logic                     op_r;
`endif

  logic                     accept;
  logic                     last_digit;
  bcd_digit_t               d_sum;
  logic                     d_cout;
  logic                     d_inv;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign last_digit = (idx == LAST);

  assign sum        = sum_r;
  assign carry_out  = carry_out_r;
  assign digit_err  = err_r;

  // The single shared digit adder, fed by the digit currently selected by idx.
  bcd_digit_adder u_digit (
    .a       (a_r[idx]),
    .b       (b_r[idx]),
`ifdef BCD_SUB_EN
    .sub     (op_r),
`else
    .sub     (1'b0),
`endif
    .cin     (carry),
    .sum     (d_sum),
    .cout    (d_cout),
    .invalid (d_inv)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept -> ripple DIGITS cycles -> hold result until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = RUN;
      RUN:     if (last_digit) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-digit ripple and result registers.
  // The result registers are left alone in DONE so the output stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      carry_out_r <= 1'b0;
      err_r       <= 1'b0;
`ifdef BCD_SUB_EN
      op_r        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r         <= a;
            b_r         <= b;
            idx         <= '0;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
            err_r       <= 1'b0;
`ifdef BCD_SUB_EN
            op_r        <= op;
            // Seeding the carry with op supplies the +1 of the ten's complement.
            carry       <= op;
`else
            carry       <= 1'b0;
`endif
          end
        end
        RUN: begin
          sum_r[idx] <= d_sum;
          carry      <= d_cout;
          err_r      <= err_r | d_inv;
          if (last_digit) carry_out_r <= d_cout;
          else            idx         <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_add_sequencer.sv
// Self-checking bench for bcd_add_sequencer: directed vectors with literal
// expectations plus a cycle-level reference model checked every falling edge.
module tb_bcd_add_sequencer;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         digit_err;

  int n_chk = 0;
  int n_err = 0;

  bcd_add_sequencer #(.DIGITS(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef BCD_SUB_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .digit_err (digit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: digit-serial decimal addition with the nines
  // complement for subtract. Returns {err, carry, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic sub);
    int c, ad, bd, s;
    logic err;
    logic [W-1:0] r;
    c   = sub ? 1 : 0;
    err = 1'b0;
    r   = '0;
    for (int i = 0; i < D; i++) begin
      ad = int'(x[4*i +: 4]);
      bd = int'(y[4*i +: 4]);
      if (ad > 9 || bd > 9) err = 1'b1;
      if (sub) bd = (9 - bd + 16) % 16;
      s = ad + bd + c;
      if (s > 9) begin
        r[4*i +: 4] = 4'((s + 6) % 16);
        c = 1;
      end else begin
        r[4*i +: 4] = 4'(s);
        c = 0;
      end
    end
    return {err, (c != 0), r};
  endfunction

  // Transaction-level model of the handshake: idle / busy for D cycles / done.
  int           m_phase = 0;
  int           m_cnt   = 0;
  logic [W+1:0] m_res   = '0;

  always @(negedge rst_n) begin
    m_phase = 0;
    m_cnt   = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      case (m_phase)
        0: if (in_valid) begin
             m_res   = model(a, b, op);
             m_phase = 1;
             m_cnt   = D;
           end
        1: begin
             m_cnt--;
             if (m_cnt == 0) m_phase = 2;
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, (m_phase == 0)});
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, (m_phase == 2)});
      if (m_phase == 2) begin
        chk("m_sum", 32'(sum), 32'(m_res[W-1:0]));
        chk("m_carry", {31'd0, carry_out}, {31'd0, m_res[W]});
        chk("m_err", {31'd0, digit_err}, {31'd0, m_res[W+1]});
      end
    end
  end

  // Issue one operation, check latency and literal result; optionally release.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xop,
                        input logic [W-1:0] es, input logic ec, input logic ee,
                        input logic release_it);
    int edges;
    @(negedge clk);
    a = xa; b = xb; op = xop; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(posedge clk);
      #1 edges++;
    end
    chk("latency", 32'(edges), 32'(D));
    chk("sum", 32'(sum), 32'(es));
    chk("carry_out", {31'd0, carry_out}, {31'd0, ec});
    chk("digit_err", {31'd0, digit_err}, {31'd0, ee});
    if (release_it) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("release_idle", {31'd0, in_ready}, 32'd1);
      chk("release_ov", {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_carry", {31'd0, carry_out}, 32'd0);
    chk("rst_err", {31'd0, digit_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1);
    run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op(16'h12A4, 16'h0000, 1'b0, 16'h1304, 1'b0, 1'b1, 1'b1);
    run_op(16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    run_op(16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 16'h5554, 1'b1, 1'b1, 1'b1);

    // Back-pressure: result must hold while new operands are offered.
    run_op(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a = 16'h7777; b = 16'h1111; in_valid = (k % 2 == 0);
      @(posedge clk);
      #1;
      chk("hold_ov", {31'd0, out_valid}, 32'd1);
      chk("hold_sum", 32'(sum), 32'h0010);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("hold_release", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of RUN abandons the operation.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_carry", {31'd0, carry_out}, 32'd0);
    chk("mid_rst_err", {31'd0, digit_err}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1);

`ifdef BCD_SUB_EN
    run_op(16'h0100, 16'h0001, 1'b1, 16'h0099, 1'b1, 1'b0, 1'b1);
    run_op(16'h0050, 16'h0075, 1'b1, 16'h9975, 1'b0, 1'b0, 1'b1);
    run_op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    op = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
